univ_shiftreg_burst: RTL and testbench
======================================

// Module: univ_shiftreg_burst
// PURPOSE
//   Parametrised bidirectional shift register with parallel load and a burst sequencer
//   that performs COUNT consecutive shifts from one start request.
//   Next generation of the 4-bit bidir shift register used by the PT2262/PT2272 encoder
//   and decoder datapaths.
//   Serialises an address/data word for the encoder without per-bit control from the
//   outer FSM.
// PARAMETERS
//   N   4  register width in bits (N >= 2)
//   CW  3  width of count / cnt_left (burst length 0 .. 2**CW-1)
// PORTS
//   clk              in   1   rising-edge clock
//   rst              in   1   asynchronous active-high reset
//   en               in   1   clock enable; no state change when 0
//   op               in   2   00 hold, 01 shift left, 10 shift right, 11 parallel load
//   shift_in         in   1   serial fill bit (into q[0] on left, q[N-1] on right)
//   d                in   N   parallel load data
//   start            in   1   burst request; qualified by en and !busy
//   count            in   CW  burst length, sampled on accept
//   rot              in   1   rotate select; port present only with SHIFTREG_ROTATE_EN
//   q                out  N   register contents
//   shift_out_left   out  1   combinational q[N-1]
//   shift_out_right  out  1   combinational q[0]
//   busy             out  1   burst in progress
//   done             out  1   one-cycle pulse after the final burst shift
//   cnt_left         out  CW  shifts remaining in the current burst
// BEHAVIOUR
//   - Reset (async, immediate): q=0, busy=0, done=0, cnt_left=0, FSM=IDLE.
//   - done is cleared on every clock edge where it is not being set.
//   - FSM states are IDLE and BURST.
//   - IDLE, en=1, start=0: op executes one step.
//       01: q <= {q[N-2:0], shift_in}; 10: q <= {shift_in, q[N-1:1]};
//       11: q <= d; 00: hold.
//   - IDLE, en=1, start=1, op in {01,10}, count>0: accept.
//       Perform the first shift on that edge; latch direction; cnt_left <= count-1.
//       If count==1: done <= 1, stay IDLE.
//       Otherwise: busy <= 1, go to BURST.
//   - start=1 with count==0: no shift, no busy, no done.
//   - start=1 with op in {00,11}: executes op as a single step; no burst.
//   - BURST, en=1: shift in latched direction; cnt_left decrements.
//       On the edge where cnt_left goes 1->0: busy <= 0, done <= 1, go to IDLE.
//   - BURST: op, d, start and count are ignored.
//       shift_in is still sampled on every shift.
//   - BURST, en=0: stall; q, cnt_left and busy hold; done is not asserted.
//   - Latency: count=K completes K en-cycles after accept.
//       done is high during the cycle after the final shift edge.
//   - Reset mid-burst aborts the burst; no done is issued.
//   - count > N is legal; excess shifts fill with shift_in (or rotate).
//   - A new start is accepted in the same cycle done is high (back-to-back bursts).
// CONFIGURATION
//   SHIFTREG_ROTATE_EN defined:
//     rot port exists; when rot=1 the vacated bit takes the bit shifted out.
//     Left: q <= {q[N-2:0], q[N-1]}. Right: q <= {q[0], q[N-1:1]}.
//     rot is sampled per shift, including during a burst.
//   SHIFTREG_ROTATE_EN undefined: no rot port; all shifts fill from shift_in.
// TESTING (N=4, CW=3)
//   1. Load: op=11, d=1010, en=1
//      -> q=1010, shift_out_left=1, shift_out_right=0.
//   2. Right burst: from 1010, start=1, op=10, count=3, shift_in=0
//      -> q steps 0101, 0010, 0001; busy high for 2 cycles; single done pulse; cnt_left=0.
//   3. Stalled left burst: load 1111, start op=01 count=2, then en=0 for 2 cycles
//      -> q holds 1110 with busy=1 while stalled; then 1100 and done pulses once.
//   4. Reset mid-burst: start count=5, assert rst after 2 shifts
//      -> q=0000, busy=0, done=0, cnt_left=0 immediately.
//      -> no done after rst is released.
//   5. Rotate: load 1001, start op=10 count=4 shift_in=0
//      -> with SHIFTREG_ROTATE_EN and rot=1: q=1001, done pulses.
//      -> without SHIFTREG_ROTATE_EN: q=0000.
//   6. Null requests: op=00 en=1 -> q unchanged.
//      start=1, op=01, count=0 -> q unchanged, busy=0, done=0.
//      en=0 with op=11 -> q unchanged.

Source files
------------

// File: rtl/univ_shiftreg_burst.sv
// univ_shiftreg_burst: N-bit bidirectional shift register with parallel load
// and a burst sequencer that runs COUNT back-to-back shifts from one start.
// Optional feature macro: SHIFTREG_ROTATE_EN (adds the rot port; rot=1 turns
// shifts into rotates by feeding the shifted-out bit back into the vacated end).

// Per-bit next-value mux; one instance per register bit.
module univ_shiftreg_burst_cell (
  input  logic [1:0] mode,    // 00 hold, 01 take lower neighbour, 10 take upper, 11 load
  input  logic       cur,
  input  logic       lo_bit,
  input  logic       hi_bit,
  input  logic       ld_bit,
  output logic       nxt
);
  // select this bit's next value from the requested operation
  always_comb begin
    nxt = cur;
    case (mode)
      2'b01:   nxt = lo_bit;
      2'b10:   nxt = hi_bit;
      2'b11:   nxt = ld_bit;
      default: nxt = cur;
    endcase
  end
endmodule

module univ_shiftreg_burst #(
  parameter int N  = 4,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [1:0]    op,
  input  logic          shift_in,
  input  logic [N-1:0]  d,
  input  logic          start,
  input  logic [CW-1:0] count,
`ifdef SHIFTREG_ROTATE_EN
  input  logic          rot,
`endif
  output logic [N-1:0]  q,
  output logic          shift_out_left,
  output logic          shift_out_right,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] cnt_left
);

  localparam logic [1:0] OP_HOLD  = 2'b00;
  localparam logic [1:0] OP_LEFT  = 2'b01;
  localparam logic [1:0] OP_RIGHT = 2'b10;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  q_q, q_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dir_q, dir_d;     // latched burst direction, 1 = right
  logic          done_q, done_d;
  logic [1:0]    mode;
  logic          rot_s;
  logic          fill_l, fill_r;
  logic [N-1:0]  lo_v, hi_v;

`ifdef SHIFTREG_ROTATE_EN
  assign rot_s = rot;
`else
  assign rot_s = 1'b0;
`endif

  // Bit entering the vacated end: serial input, or the bit leaving the other end when rotating.
  assign fill_l = rot_s ? q_q[N-1] : shift_in;
  assign fill_r = rot_s ? q_q[0]   : shift_in;
  assign lo_v   = {q_q[N-2:0], fill_l};
  assign hi_v   = {fill_r, q_q[N-1:1]};

  genvar g;
  generate
    for (g = 0; g < N; g++) begin : g_bit
      univ_shiftreg_burst_cell u_cell (
        .mode   (mode),
        .cur    (q_q[g]),
        .lo_bit (lo_v[g]),
        .hi_bit (hi_v[g]),
        .ld_bit (d[g]),
        .nxt    (q_d[g])
      );
    end
  endgenerate

  // Sequencer: decides the register operation and burst bookkeeping for this edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    done_d  = 1'b0;                 // done only ever lasts one cycle
    mode    = OP_HOLD;
    if (en) begin
      case (state_q)
        IDLE: begin
          if (start && (op == OP_LEFT || op == OP_RIGHT)) begin
            // A zero-length burst request is a no-op, not a plain shift.
            if (count != '0) begin
              mode  = op;
              dir_d = (op == OP_RIGHT);
              cnt_d = count - CW'(1);
              if (count == CW'(1)) done_d  = 1'b1;
              else                 state_d = BURST;
            end
          end else begin
            mode = op;
          end
        end
        BURST: begin
          mode  = dir_q ? OP_RIGHT : OP_LEFT;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers; reset aborts any burst immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

  assign q               = q_q;
  assign shift_out_left  = q_q[N-1];
  assign shift_out_right = q_q[0];
  assign busy            = (state_q == BURST);
  assign done            = done_q;
  assign cnt_left        = cnt_q;

endmodule

// File: tb/tb_univ_shiftreg_burst.sv
// Directed + randomized bench for univ_shiftreg_burst (N=4, CW=3) against a
// behavioural model of the burst register.
module tb_univ_shiftreg_burst;
  localparam int N  = 4;
  localparam int CW = 3;
`ifdef SHIFTREG_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  logic          clk, rst, en, shift_in, start, rot;
  logic [1:0]    op;
  logic [N-1:0]  d, q;
  logic [CW-1:0] count, cnt_left;
  logic          sol, sor, busy, done;

  int n_cmp = 0;
  int n_err = 0;

  // model state
  logic [N-1:0] mq;
  bit           m_busy, m_done, m_right;
  int           m_left;

  univ_shiftreg_burst #(.N(N), .CW(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .op(op), .shift_in(shift_in), .d(d),
    .start(start), .count(count),
`ifdef SHIFTREG_ROTATE_EN
    .rot(rot),
`endif
    .q(q), .shift_out_left(sol), .shift_out_right(sor),
    .busy(busy), .done(done), .cnt_left(cnt_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".q"},    32'(q),        32'(mq));
    chk({tag, ".sol"},  32'(sol),      32'(mq / (2 ** (N - 1))));
    chk({tag, ".sor"},  32'(sor),      32'(mq % 2));
    chk({tag, ".busy"}, 32'(busy),     32'(m_busy));
    chk({tag, ".done"}, 32'(done),     32'(m_done));
    chk({tag, ".cnt"},  32'(cnt_left), 32'(m_left));
  endtask

  function automatic logic [N-1:0] do_shift(input logic [N-1:0] v, input bit right);
    logic f;
    logic [N-1:0] r;
    if (ROT_EN && rot) f = right ? v[0] : v[N-1];
    else               f = shift_in;
    if (right) r = (v >> 1) | (N'(f) << (N - 1));
    else       r = (v << 1) | N'(f);
    return r;
  endfunction

  task automatic model_reset();
    mq = '0; m_busy = 0; m_done = 0; m_left = 0; m_right = 0;
  endtask

  // Predict the edge from the current inputs, clock it, then compare.
  task automatic tick(input string tag);
    logic [N-1:0] nq;
    bit nd;
    nq = mq;
    nd = 0;
    if (en) begin
      if (!m_busy) begin
        if (start && (op == 2'b01 || op == 2'b10)) begin
          if (count != 0) begin
            m_right = (op == 2'b10);
            nq      = do_shift(mq, m_right);
            m_left  = int'(count) - 1;
            if (count == 1) nd = 1;
            else            m_busy = 1;
          end
        end else if (op == 2'b01) nq = do_shift(mq, 0);
        else if (op == 2'b10)     nq = do_shift(mq, 1);
        else if (op == 2'b11)     nq = d;
      end else begin
        nq = do_shift(mq, m_right);
        m_left--;
        if (m_left == 0) begin
          m_busy = 0;
          nd     = 1;
        end
      end
    end
    @(posedge clk);
    #1;
    mq = nq;
    m_done = nd;
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; op = 2'b00; shift_in = 1'b0; start = 1'b0;
    rot = 1'b0; d = '0; count = '0;
    model_reset();
    #2;
    check_all("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // 1. parallel load
    en = 1'b1; op = 2'b11; d = 4'b1010;
    tick("load");
    chk("load.q_exact", 32'(q), 32'b1010);
    chk("load.sol_exact", 32'(sol), 32'd1);
    chk("load.sor_exact", 32'(sor), 32'd0);

    // 2. right burst of 3
    start = 1'b1; op = 2'b10; count = 3'd3; shift_in = 1'b0;
    tick("rb0");
    chk("rb0.q_exact", 32'(q), 32'b0101);
    start = 1'b0; op = 2'b11; d = 4'b1111; count = 3'd7;  // ignored while bursting
    tick("rb1");
    chk("rb1.q_exact", 32'(q), 32'b0010);
    tick("rb2");
    chk("rb2.q_exact", 32'(q), 32'b0001);
    chk("rb2.done_exact", 32'(done), 32'd1);
    op = 2'b00;
    tick("rb3");

    // 3. stalled left burst
    op = 2'b11; d = 4'b1111;
    tick("ld1111");
    start = 1'b1; op = 2'b01; count = 3'd2; shift_in = 1'b0;
    tick("lb0");
    start = 1'b0; op = 2'b00; en = 1'b0;
    tick("lb_stall0");
    tick("lb_stall1");
    chk("lb_stall.q_exact", 32'(q), 32'b1110);
    en = 1'b1;
    tick("lb1");
    chk("lb1.q_exact", 32'(q), 32'b1100);
    tick("lb2");

    // 4. reset mid-burst
    start = 1'b1; op = 2'b01; count = 3'd5; shift_in = 1'b1;
    tick("rst_b0");
    start = 1'b0;
    tick("rst_b1");
    async_reset("rst_mid");
    chk("rst_mid.q_exact", 32'(q), 32'd0);
    op = 2'b00;
    for (int i = 0; i < 6; i++) tick("post_rst");

    // 5. rotate / fill
    op = 2'b11; d = 4'b1001;
    tick("ld1001");
    start = 1'b1; op = 2'b10; count = 3'd4; shift_in = 1'b0; rot = 1'b1;
    tick("rot0");
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick("rot");
`ifdef SHIFTREG_ROTATE_EN
    chk("rot.q_exact", 32'(q), 32'b1001);
`else
    chk("rot.q_exact", 32'(q), 32'b0000);
`endif
    rot = 1'b0; op = 2'b00;
    tick("rot_end");

    // 6. null requests
    op = 2'b11; d = 4'b0110;
    tick("ld0110");
    op = 2'b00;
    tick("hold");
    start = 1'b1; op = 2'b01; count = 3'd0;
    tick("cnt0");
    start = 1'b0; en = 1'b0; op = 2'b11; d = 4'b1111;
    tick("en0");
    chk("null.q_exact", 32'(q), 32'b0110);

    // back-to-back: new start while done is high
    en = 1'b1; start = 1'b1; op = 2'b01; count = 3'd1; shift_in = 1'b1;
    tick("b2b0");
    count = 3'd2;
    tick("b2b1");
    start = 1'b0;
    tick("b2b2");

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      en       = ($urandom_range(0, 9) != 0);
      op       = 2'($urandom_range(0, 3));
      start    = ($urandom_range(0, 2) == 0);
      count    = CW'($urandom_range(0, 7));
      shift_in = 1'($urandom);
      rot      = 1'($urandom);
      d        = N'($urandom);
      if ($urandom_range(0, 99) == 0) async_reset("rand_rst");
      tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
